// File: rtl/ov7670_frame_sequencer_pkg.sv
// Shared types and default geometry for the OV7670 -> ILI9341 stream path.
package ov7670_stream_pkg;

  localparam int unsigned DEF_BYTES_PER_LINE = 640;  // 320 px RGB565
  localparam int unsigned DEF_LINES          = 240;
  localparam int unsigned DEF_FIFO_DEPTH     = 16;

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    WAIT_VSYNC = 2'd1,
    SYNC       = 2'd2,
    ACTIVE     = 2'd3
  } seq_state_t;

  // Pointer width for a power-of-two FIFO; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Streaming is reported once a frame has been locked onto.
  function automatic logic in_stream(input seq_state_t s);
    return (s == SYNC) || (s == ACTIVE);
  endfunction

endpackage

// File: rtl/ov7670_frame_sequencer_byte_fifo.sv
// Small synchronous byte FIFO with show-ahead head and a flush input.
// Simultaneous push/pop is always allowed, including when full.
module byte_fifo
  import ov7670_stream_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       buttonReset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO only lands when the head leaves the same cycle.
  always_comb begin
    do_push = push & (~full | pop);
    do_pop  = pop & ~empty;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ov7670_frame_sequencer.sv
// Camera-to-TFT frame sequencer: synchronises OV7670 timing into clk,
// captures line bytes, buffers them and streams them to the TFT driver,
// starting and stopping only on frame boundaries.
module ov7670_frame_sequencer
  import ov7670_stream_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = DEF_BYTES_PER_LINE,
  parameter int unsigned LINES          = DEF_LINES,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       buttonReset,
  input  logic       stream_en,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_pclk,
  input  logic [7:0] cam_data,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       streaming,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned BCW = $clog2(BYTES_PER_LINE + 1);
  localparam int unsigned LCW = $clog2(LINES + 1);
  localparam logic [BCW-1:0] BYTE_MAX = '1;
  localparam logic [LCW-1:0] LINE_MAX = '1;

  // Synchroniser stages plus the one-clk-older copy used for edge detection
  logic       vsync_s1, vsync_s2, vsync_d;
  logic       href_s1, href_s2, href_d;
  logic       pclk_s1, pclk_s2, pclk_d;
  logic [7:0] data_s1, data_s2;

  // Registered events, all aligned to the same clk
  logic       vs_rise_e, vs_fall_e, href_fall_e, href_e, pclk_rise_e;
  logic [7:0] data_e;

  // Capture stage feeding the FIFO
  logic       cap_push;
  logic [7:0] cap_data;

  seq_state_t     state;
  logic           pend_start;
  logic [BCW-1:0] byte_cnt;
  logic [LCW-1:0] line_cnt;

  logic       capture;
  logic       do_flush;
  logic       frame_end;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_dout;

  // Two-flop synchronisers; cam_data gets a matching two-stage delay.
  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_d <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0; href_d  <= 1'b0;
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_d  <= 1'b0;
      data_s1  <= '0;   data_s2  <= '0;
    end else begin
      vsync_s1 <= cam_vsync; vsync_s2 <= vsync_s1; vsync_d <= vsync_s2;
      href_s1  <= cam_href;  href_s2  <= href_s1;  href_d  <= href_s2;
      pclk_s1  <= cam_pclk;  pclk_s2  <= pclk_s1;  pclk_d  <= pclk_s2;
      data_s1  <= cam_data;  data_s2  <= data_s1;
    end
  end

  // Edge detection, registered so every event and its byte share one timing.
  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      vs_rise_e   <= 1'b0;
      vs_fall_e   <= 1'b0;
      href_fall_e <= 1'b0;
      href_e      <= 1'b0;
      pclk_rise_e <= 1'b0;
      data_e      <= '0;
    end else begin
      vs_rise_e   <= vsync_s2 & ~vsync_d;
      vs_fall_e   <= ~vsync_s2 & vsync_d;
      href_fall_e <= ~href_s2 & href_d;
      href_e      <= href_s2;
      pclk_rise_e <= pclk_s2 & ~pclk_d;
      data_e      <= data_s2;
    end
  end

  // Frame-boundary decisions and handshake.
  // Pipeline from the clk that first samples pclk high: s1, s2, event reg,
  // capture reg, FIFO write -> byte visible 4 clk later.
  always_comb begin
    capture   = pclk_rise_e & href_e & (state == ACTIVE);
    frame_end = (state == ACTIVE) & vs_rise_e;
    do_flush  = ((state == WAIT_VSYNC) & vs_rise_e) | pend_start;
    pop       = pix_valid & pix_ready;
  end

  // Sequencer FSM, geometry counters and frame strobes.
  // A restart after frame_done is deferred one clk via pend_start so that
  // frame_start always follows frame_done and never coincides with it.
  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      state       <= DISABLED;
      pend_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      frame_err   <= 1'b0;
      cap_push    <= 1'b0;
      cap_data    <= '0;
    end else begin
      frame_start <= do_flush;
      frame_done  <= frame_end;
      pend_start  <= 1'b0;
      cap_push    <= capture;
      cap_data    <= data_e;

      if (do_flush) begin
        byte_cnt <= '0;
        line_cnt <= '0;
        if (!fifo_empty) frame_err <= 1'b1;
      end

      case (state)
        DISABLED: begin
          if (stream_en) state <= WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (!stream_en)     state <= DISABLED;
          else if (vs_rise_e) state <= SYNC;
        end
        SYNC: begin
          if (vs_fall_e) state <= ACTIVE;
        end
        ACTIVE: begin
          if (capture && byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + BCW'(1);
          if (href_fall_e) begin
            if (byte_cnt != '0) begin
              if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LCW'(1);
              if (byte_cnt != BCW'(BYTES_PER_LINE)) frame_err <= 1'b1;
            end
            byte_cnt <= '0;
          end
          if (vs_rise_e) begin
            if (line_cnt != LCW'(LINES)) frame_err <= 1'b1;
            if (stream_en) begin
              pend_start <= 1'b1;
              state      <= SYNC;
            end else begin
              state <= DISABLED;
            end
          end
        end
        default: state <= DISABLED;
      endcase
    end
  end

  // Sticky overflow: a captured byte found the FIFO full with nothing leaving.
  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      overflow <= 1'b0;
    end else if (cap_push && fifo_full && !pop && !do_flush) begin
      overflow <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .buttonReset(buttonReset),
    .push       (cap_push),
    .pop        (pop),
    .flush      (do_flush),
    .din        (cap_data),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign pix_data  = fifo_dout;
  assign pix_valid = ~fifo_empty;
  assign streaming = in_stream(state);

endmodule
